// File: rtl/mem_copy.sv
// Byte-copy engine that shares a single-port data memory with a CPU.
// It moves len bytes from src to dst, taking two cycles per byte, and stalls the CPU while a copy is running.
module mem_copy #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic [WIDTH-1:0] len,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_d,
    input  logic             cpu_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_d_in,
    output logic             mem_en,
    input  logic [WIDTH-1:0] mem_d_out,
    output logic             busy,
    output logic             done,
    output logic             cpu_stall
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] src_ptr_r;
    logic [WIDTH-1:0] dst_ptr_r;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] buf_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] mem_addr_s;
    logic [WIDTH-1:0] mem_d_in_s;
    logic             mem_en_s;

    // State register, latched operands, byte buffer and registered status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            src_ptr_r <= CNT_ZERO;
            dst_ptr_r <= CNT_ZERO;
            cnt_r     <= CNT_ZERO;
            buf_r     <= CNT_ZERO;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            // Status flags follow the state being entered so they line up with it
            busy_r  <= (state_s == ST_READ) || (state_s == ST_WRITE);
            done_r  <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        src_ptr_r <= src;
                        dst_ptr_r <= dst;
                        cnt_r     <= len;
                    end
                end
                ST_READ: begin
                    buf_r <= mem_d_out;
                end
                ST_WRITE: begin
                    src_ptr_r <= src_ptr_r + CNT_ONE;
                    dst_ptr_r <= dst_ptr_r + CNT_ONE;
                    cnt_r     <= cnt_r - CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode and memory port steering
    always_comb begin
        state_s    = state_r;
        mem_addr_s = cpu_addr;
        mem_d_in_s = cpu_d;
        mem_en_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                mem_en_s = cpu_we;
                if (start) begin
                    state_s = (len == CNT_ZERO) ? ST_DONE : ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                mem_addr_s = src_ptr_r;
                mem_d_in_s = buf_r;
                state_s    = ST_WRITE;
            end
            ST_WRITE: begin
                mem_addr_s = dst_ptr_r;
                mem_d_in_s = buf_r;
                mem_en_s   = 1'b1;
                if (cnt_r == CNT_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DONE: begin
                mem_addr_s = dst_ptr_r;
                mem_d_in_s = buf_r;
                state_s    = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Reset must silence the memory even while the CPU is requesting a write
    assign mem_en    = mem_en_s & rst;
    assign mem_addr  = mem_addr_s;
    assign mem_d_in  = mem_d_in_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cpu_stall = busy_r;

endmodule

// File: tb/tb_mem_copy.sv
// Bench for mem_copy: a behavioural memory plus a reference array that is updated by plain forward copies.
module tb_mem_copy;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] src, dst, len;
    logic [7:0] cpu_addr, cpu_d;
    logic       cpu_we;
    logic [7:0] mem_addr, mem_d_in, mem_d_out;
    logic       mem_en;
    logic       busy, done, cpu_stall;

    logic [7:0] mem   [256];
    logic [7:0] model [256];
    int tests = 0;
    int fails = 0;

    mem_copy #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .src(src), .dst(dst), .len(len),
        .cpu_addr(cpu_addr), .cpu_d(cpu_d), .cpu_we(cpu_we),
        .mem_addr(mem_addr), .mem_d_in(mem_d_in), .mem_en(mem_en),
        .mem_d_out(mem_d_out), .busy(busy), .done(done), .cpu_stall(cpu_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge when enabled
    assign mem_d_out = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_en) mem[mem_addr] <= mem_d_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem();
        for (int i = 0; i < 256; i++)
            check($sformatf("mem[%02h]", i), 32'(mem[i]), 32'(model[i]));
    endtask

    // CPU write through the idle pass-through path
    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_d = d; cpu_we = 1'b1;
        model[a] = d;
        tick();
        cpu_we = 1'b0;
    endtask

    // One full copy with cycle-by-cycle protocol checks; meddle adds a CPU write and a second start mid-copy
    task automatic run_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l, input bit meddle);
        logic [7:0] keep80;
        for (int i = 0; i < int'(l); i++) model[8'(int'(d) + i)] = model[8'(int'(s) + i)];
        keep80 = model[8'h80];
        src = s; dst = d; len = l; start = 1'b1;
        tick();
        start = 1'b0;
        if (meddle) begin
            start = 1'b1; src = 8'h00; dst = 8'h90; len = 8'd5;
            cpu_we = 1'b1; cpu_addr = 8'h80; cpu_d = 8'h5A;
        end
        for (int c = 1; c <= 2 * int'(l); c++) begin
            check($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
            check($sformatf("done_c%0d", c), 32'(done), 32'd0);
            check($sformatf("stall_c%0d", c), 32'(cpu_stall), 32'd1);
            check($sformatf("mem_en_c%0d", c), 32'(mem_en), 32'(c % 2 == 0));
            tick();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("mem_en_at_done", 32'(mem_en), 32'd0);
        if (meddle) begin
            check("cpu80_dropped", 32'(mem[8'h80]), 32'(keep80));
            start = 1'b0;
        end
        tick();
        check("done_single", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        if (meddle) begin
            check("idle_passthru_en", 32'(mem_en), 32'd1);
            check("idle_passthru_addr", 32'(mem_addr), 32'h80);
            tick();
            cpu_we = 1'b0;
            model[8'h80] = 8'h5A;
            check("cpu80_lands", 32'(mem[8'h80]), 32'h5A);
        end
        check_mem();
    endtask

    initial begin
        logic [7:0] rs, rd, rl;
        bit seen_done;
        rst = 1'b0; start = 1'b0; src = 8'h00; dst = 8'h00; len = 8'h00;
        cpu_addr = 8'h33; cpu_d = 8'hC3; cpu_we = 1'b1;

        // Reset: outputs idle and the CPU write is blocked
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        rst = 1'b1;
        cpu_we = 1'b0;
        tick();

        // Idle pass-through and random preload through the CPU port
        cpu_addr = 8'h05; cpu_d = 8'h3C; cpu_we = 1'b1; #1;
        check("pass_addr", 32'(mem_addr), 32'h05);
        check("pass_d", 32'(mem_d_in), 32'h3C);
        check("pass_en", 32'(mem_en), 32'd1);
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        check_mem();

        // Straight 4-byte copy
        poke(8'h10, 8'h11); poke(8'h11, 8'h22); poke(8'h12, 8'h33); poke(8'h13, 8'h44);
        run_copy(8'h10, 8'h40, 8'd4, 1'b0);
        check("d40", 32'(mem[8'h40]), 32'h11);
        check("d43", 32'(mem[8'h43]), 32'h44);

        // Zero length
        run_copy(8'h10, 8'h50, 8'd0, 1'b0);

        // Source pointer wraps past 0xFF
        run_copy(8'hFE, 8'h20, 8'd3, 1'b0);
        check("wrap_d22", 32'(mem[8'h22]), 32'(model[8'h00]));

        // CPU write and second start during a copy
        poke(8'h80, 8'h00);
        run_copy(8'h50, 8'hA0, 8'd6, 1'b1);

        // Overlapping forward copy replicates the first byte
        poke(8'h10, 8'hAA);
        run_copy(8'h10, 8'h11, 8'd3, 1'b0);
        check("ovl_d13", 32'(mem[8'h13]), 32'hAA);

        // Reset two bytes into a four-byte copy
        model[8'h60] = model[8'h30];
        model[8'h61] = model[8'h31];
        src = 8'h30; dst = 8'h60; len = 8'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b0; cpu_we = 1'b1; cpu_addr = 8'h70; cpu_d = 8'hEE; #1;
        check("midrst_mem_en", 32'(mem_en), 32'd0);
        tick();
        rst = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h77; #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_idle_addr", 32'(mem_addr), 32'h77);
        check("midrst_idle_en", 32'(mem_en), 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done) seen_done = 1'b1;
            tick();
        end
        check("midrst_no_done", 32'(seen_done), 32'd0);
        check_mem();

        // Start held high re-triggers on the first idle cycle after done
        model[8'hD0] = model[8'hC0];
        src = 8'hC0; dst = 8'hD0; len = 8'd1; start = 1'b1;
        tick();
        check("b2b_busy1", 32'(busy), 32'd1);
        tick();
        tick();
        check("b2b_done1", 32'(done), 32'd1);
        tick();
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_done", 32'(done), 32'd0);
        tick();
        check("b2b_retrig", 32'(busy), 32'd1);
        start = 1'b0;
        tick();
        tick();
        check("b2b_done2", 32'(done), 32'd1);
        tick();
        check("b2b_done2_end", 32'(done), 32'd0);
        check_mem();

        // Randomised copies against the reference array
        for (int n = 0; n < 6; n++) begin
            rs = 8'($urandom);
            rd = 8'($urandom);
            rl = 8'($urandom_range(0, 12));
            run_copy(rs, rd, rl, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_copy.md
MEM_COPY -- requirements
Module: mem_copy

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data and address width shared with the data memory.
REQ-002 SHALL have clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have start  input  1  copy request, sampled only in IDLE.
REQ-005 SHALL have src, dst, len  input  WIDTH each  source base, destination base and byte count, latched when start is accepted.
REQ-006 SHALL have cpu_addr, cpu_d  input  WIDTH each, and cpu_we  input  1  CPU port into memory.
REQ-007 SHALL have mem_addr, mem_d_in  output  WIDTH each, and mem_en  output  1  driving the data memory's addr, d_in and en.
REQ-008 SHALL have mem_d_out  input  WIDTH  the data memory's combinational read data.
REQ-009 SHALL have busy  output  1  high while a copy is in READ or WRITE.
REQ-010 SHALL have done  output  1  single-cycle completion pulse.
REQ-011 SHALL have cpu_stall  output  1  equal to busy; a CPU write requested while it is high is dropped.

Function
REQ-012 SHALL implement the FSM states IDLE, READ, WRITE and DONE.
REQ-013 In IDLE with start=1, SHALL latch src, dst and len into src_ptr, dst_ptr and cnt, then go to READ if len!=0 and to DONE if len==0.
REQ-014 In READ, SHALL drive mem_addr=src_ptr and mem_en=0, capture mem_d_out into buf at the clock edge, and go to WRITE.
REQ-015 In WRITE, SHALL drive mem_addr=dst_ptr, mem_d_in=buf and mem_en=1, then at the clock edge: src_ptr+1, dst_ptr+1, cnt-1; go to DONE if cnt==1, else go to READ.
REQ-016 In DONE, SHALL assert done=1 and mem_en=0 for exactly one cycle, then return to IDLE.
REQ-017 In IDLE, SHALL pass through combinationally: mem_addr=cpu_addr, mem_en=cpu_we, mem_d_in=cpu_d.
REQ-018 Outside IDLE, SHALL ignore cpu_* inputs and SHALL NOT queue dropped CPU writes.
REQ-019 SHALL use 2 cycles per byte; a start accepted at edge k SHALL put the FSM in DONE (done=1) during cycle k+2*len+1, and in cycle k+1 when len=0.
REQ-020 SHALL wrap pointers modulo 2^WIDTH (0xFF+1 -> 0x00 for WIDTH=8), with no error flag.
REQ-021 SHALL copy strictly forward byte by byte; for overlapping regions with dst>src, the result is defined as source bytes replicated with period dst-src (no memmove semantics).
REQ-022 SHALL ignore start while not in IDLE (including DONE); the latched operands SHALL NOT change mid-copy.
REQ-023 SHALL treat len=0 as zero bytes: no mem_en pulse, done still pulses once.
REQ-024 SHALL produce a single-cycle DONE then IDLE for back-to-back starts, so a start held high re-triggers on the first IDLE cycle after done.

Reset
REQ-025 When rst=0 at a clock edge, SHALL set state=IDLE, busy=0, done=0 and src_ptr=dst_ptr=cnt=buf=0.
REQ-026 While rst=0, SHALL force mem_en=0 regardless of state or cpu_we.
REQ-027 Reset mid-copy SHALL abort the copy: bytes already written remain, no done pulse is issued, and the first cycle after release is IDLE.

Verification
REQ-028 Directed: MEM[0x10..0x13]=11,22,33,44; start with src=0x10, dst=0x40, len=4 -> busy for 8 cycles, done on the 9th cycle after start, MEM[0x40..0x43]=11,22,33,44.
REQ-029 Directed: len=0 -> done pulses in the cycle after start, busy never rises, mem_en stays 0.
REQ-030 Directed: src=0xFE, dst=0x20, len=3 -> bytes read from 0xFE, 0xFF and 0x00 are written to 0x20..0x22.
REQ-031 Directed: during a copy, cpu_we=1 with cpu_addr=0x80 and cpu_d=0x5A, plus a second start -> MEM[0x80] unchanged, cpu_stall=1, second start ignored; after done the same CPU write lands.
REQ-032 Directed: rst=0 asserted after 2 bytes of a 4-byte copy -> first 2 destination bytes written, last 2 untouched, no done pulse, FSM IDLE with mem_en=0.
REQ-033 Directed: overlap with src=0x10, dst=0x11, len=3 and MEM[0x10]=0xAA -> MEM[0x11..0x13]=0xAA.
